// File: rtl/uart_transmit_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmit_if
//  Description : Byte handshake between the CPU-side IO logic and the UART
//                transmitter.
//                  DataIn      [7:0]  byte to transmit (producer -> tx)
//                  DataInValid        producer has a byte on DataIn
//                  DataInReady        transmitter can accept a byte
//                master : CPU-side IO logic (drives DataIn / DataInValid)
//                slave  : uart_transmit (drives DataInReady)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_transmit_if;
   logic [7:0] DataIn;
   logic       DataInValid;
   logic       DataInReady;

   modport master (
      output DataIn,
      output DataInValid,
      input  DataInReady
   );

   modport slave (
      input  DataIn,
      input  DataInValid,
      output DataInReady
   );
endinterface
`default_nettype wire

// File: rtl/uart_transmit.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmit
//  Description : Serial transmit half of the memory-mapped UART. Accepts one
//                byte per valid/ready handshake and sends it as an 8N1 frame
//                (start, 8 data bits LSB first, stop), each symbol exactly
//                ClockFreq/BaudRate clocks long.
//                Optional macro UART_TX_PARITY_EN inserts an even-parity
//                symbol between data bit 7 and the stop bit (11-symbol frame).
//  Ports       : Clock   in   system clock, rising edge
//                Reset   in   asynchronous, active-low reset
//                tx_if   slave modport of uart_transmit_if (byte handshake)
//                SOut    out  registered serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmit #(
   parameter int ClockFreq = 100_000_000,
   parameter int BaudRate  = 115_200
) (
   input  wire logic      Clock,
   input  wire logic      Reset,
   uart_transmit_if.slave tx_if,
   output logic           SOut
);

   localparam int SymbolEdgeTime = ClockFreq / BaudRate;
   localparam int c_cnt_w        = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SymbolEdgeTime - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t             r_state;
   logic [c_cnt_w-1:0] r_count;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_ready;
`ifdef UART_TX_PARITY_EN
   logic               r_parity;
`endif

   logic w_accept;
   logic w_sym_end;

   // Ready is a registered flag, so a handshake only needs one AND here.
   assign w_accept          = tx_if.DataInValid && r_ready;
   assign w_sym_end         = (r_count == c_cnt_last);
   assign tx_if.DataInReady = r_ready;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         // SOut resets high so an abandoned frame never shows a low glitch.
         r_state   <= IDLE;
         SOut      <= 1'b1;
         r_ready   <= 1'b0;
         r_count   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         // Symbol timer free-runs in every active state and wraps at the
         // terminal count, which is also where the next symbol is driven.
         if (r_state != IDLE) begin
            if (w_sym_end)
               r_count <= '0;
            else
               r_count <= r_count + c_cnt_w'(1);
         end

         case (r_state)
            IDLE: begin
               r_count <= '0;
               SOut    <= 1'b1;
               if (w_accept) begin
                  r_shift   <= tx_if.DataIn;
                  r_state   <= START;
                  SOut      <= 1'b0;
                  r_ready   <= 1'b0;
                  r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                  // Captured at load so it is independent of the shifting.
                  r_parity  <= ^tx_if.DataIn;
`endif
               end else begin
                  // Covers the first edge after reset release.
                  r_ready <= 1'b1;
               end
            end

            START: begin
               if (w_sym_end) begin
                  r_state <= DATA;
                  SOut    <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
            end

            DATA: begin
               if (w_sym_end) begin
                  if (r_bit_idx != 3'd7) begin
                     // r_shift[0] already holds the next bit to send.
                     SOut      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end else begin
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
                     SOut    <= r_parity;
`else
                     r_state <= STOP;
                     SOut    <= 1'b1;
`endif
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_sym_end) begin
                  r_state <= STOP;
                  SOut    <= 1'b1;
               end
            end
`endif

            STOP: begin
               if (w_sym_end) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  SOut    <= 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
               SOut    <= 1'b1;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_transmit
//  Description : Self-checking bench for uart_transmit at ClockFreq=1 MHz,
//                BaudRate=100 kHz (10 clocks per symbol). Table of bytes with
//                hand-written expected frames, plus hand sequences for reset,
//                back-to-back transfers and reset in the middle of a frame.
//                Build with UART_TX_PARITY_EN defined to exercise parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmit;

   localparam int c_clk_hz = 1_000_000;
   localparam int c_baud   = 100_000;
   localparam int N        = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NSYM     = 11;
`else
   localparam int NSYM     = 10;
`endif
   localparam int NV       = 5;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;   // bit j = expected level of symbol j
      bit          poke;    // disturb DataIn/DataInValid mid-frame
   } vec_t;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   logic SOut;

   uart_transmit_if bus();

   uart_transmit #(
      .ClockFreq(c_clk_hz),
      .BaudRate (c_baud)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .tx_if(bus),
      .SOut (SOut)
   );

   always #5 Clock = ~Clock;

   int   n_vec = 0;
   int   n_err = 0;
   logic sl [0:511];
   logic rl [0:511];
   vec_t vt [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Compare one logged frame starting at sample 'base' symbol by symbol:
   // count the high samples in each N-clock window.
   task automatic check_frame(input string name, input int base, input logic [10:0] frame);
      int ones;
      int rdy;
      rdy = 0;
      for (int j = 0; j < NSYM; j++) begin
         ones = 0;
         for (int c = 0; c < N; c++) begin
            ones += int'(sl[base + j*N + c]);
            rdy  += int'(rl[base + j*N + c]);
         end
         check($sformatf("%s sym%0d highs", name, j), ones, frame[j] ? N : 0);
      end
      check($sformatf("%s ready-high clocks in frame", name), rdy, 0);
   endtask

   // Wait (bounded) for ready, present the byte, return at the first
   // negedge after the handshake edge (= sample 0 of the frame).
   task automatic start_tx(input logic [7:0] d);
      int t;
      t = 0;
      while (bus.DataInReady !== 1'b1 && t < 3*N) begin
         @(negedge Clock);
         t++;
      end
      check("ready before send", bus.DataInReady, 1);
      bus.DataIn      = d;
      bus.DataInValid = 1'b1;
      @(negedge Clock);
      bus.DataInValid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      int rdy;
      int second;
      int len;

`ifdef UART_TX_PARITY_EN
      vt[0] = '{data: 8'h07, frame: 11'b11000001110, poke: 1'b0};
      vt[1] = '{data: 8'h03, frame: 11'b10000000110, poke: 1'b0};
      vt[2] = '{data: 8'h55, frame: 11'b10010101010, poke: 1'b0};
      vt[3] = '{data: 8'hA3, frame: 11'b10101000110, poke: 1'b1};
      vt[4] = '{data: 8'h00, frame: 11'b10000000000, poke: 1'b0};
`else
      vt[0] = '{data: 8'h55, frame: 11'b01010101010, poke: 1'b0};
      vt[1] = '{data: 8'hA3, frame: 11'b01101000110, poke: 1'b1};
      vt[2] = '{data: 8'h3C, frame: 11'b01001111000, poke: 1'b0};
      vt[3] = '{data: 8'hFF, frame: 11'b01111111110, poke: 1'b0};
      vt[4] = '{data: 8'h00, frame: 11'b01000000000, poke: 1'b0};
`endif

      bus.DataIn      = 8'h00;
      bus.DataInValid = 1'b0;

      // ---------------- reset values ----------------
      #1 Reset = 1'b0;
      ones = 0;
      rdy  = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         ones += int'(SOut);
         rdy  += int'(bus.DataInReady);
      end
      check("reset SOut high clocks", ones, 5);
      check("reset ready high clocks", rdy, 0);
      Reset = 1'b1;
      #1 check("ready before first edge after release", bus.DataInReady, 0);
      @(negedge Clock);
      check("ready after first edge", bus.DataInReady, 1);
      check("idle SOut", SOut, 1);

      // ---------------- table-driven frames ----------------
      for (int v = 0; v < NV; v++) begin
         start_tx(vt[v].data);
         for (int i = 0; i < NSYM*N; i++) begin
            sl[i] = SOut;
            rl[i] = bus.DataInReady;
            if (vt[v].poke && i == 25) begin
               bus.DataIn      = 8'hFF;
               bus.DataInValid = 1'b1;
            end
            if (vt[v].poke && i == 28)
               bus.DataInValid = 1'b0;
            @(negedge Clock);
         end
         check_frame($sformatf("vec%0d(%02h)", v, vt[v].data), 0, vt[v].frame);
         check($sformatf("vec%0d ready after frame", v), bus.DataInReady, 1);
         ones = 0;
         for (int i = 0; i < 2*N; i++) begin
            ones += int'(SOut);
            @(negedge Clock);
         end
         check($sformatf("vec%0d idle line highs", v), ones, 2*N);
      end

      // ---------------- back-to-back with valid held high ----------------
      bus.DataIn      = 8'h00;
      bus.DataInValid = 1'b1;
      @(negedge Clock);
      bus.DataIn = 8'hFF;
      second = -1;
      len    = 2*NSYM*N + 2;
      for (int i = 0; i < len; i++) begin
         sl[i] = SOut;
         rl[i] = bus.DataInReady;
         if (i > 0 && second < 0 && sl[i-1] == 1'b1 && sl[i] == 1'b0) begin
            second          = i;
            bus.DataInValid = 1'b0;
         end
         @(negedge Clock);
      end
      bus.DataInValid = 1'b0;
      check("b2b start-to-start clocks", second, NSYM*N + 1);
      if (second < 0) second = NSYM*N + 1;
      ones = 0;
      for (int i = 0; i < second; i++) ones += int'(sl[i]);
      check("b2b first stop-bit clocks", ones, N + 1);
`ifdef UART_TX_PARITY_EN
      check_frame("b2b frame1(00)", 0, 11'b10000000000);
      check_frame("b2b frame2(FF)", second, 11'b10111111110);
`else
      check_frame("b2b frame1(00)", 0, 11'b01000000000);
      check_frame("b2b frame2(FF)", second, 11'b01111111110);
`endif
      check("b2b ready after second frame", rl[second + NSYM*N], 1);

      // ---------------- reset in the middle of a frame ----------------
      start_tx(8'h00);
      for (int i = 0; i < 35; i++) @(negedge Clock);
      check("SOut low before mid-frame reset", SOut, 0);
      #2 Reset = 1'b0;
      #1 check("SOut high right after async reset", SOut, 1);
      check("ready low right after async reset", bus.DataInReady, 0);
      for (int i = 0; i < 3; i++) @(negedge Clock);
      check("SOut held high in reset", SOut, 1);
      Reset = 1'b1;
      @(negedge Clock);
      check("ready after mid-frame reset release", bus.DataInReady, 1);
      start_tx(8'h81);
      for (int i = 0; i < NSYM*N; i++) begin
         sl[i] = SOut;
         rl[i] = bus.DataInReady;
         @(negedge Clock);
      end
`ifdef UART_TX_PARITY_EN
      check_frame("post-reset(81)", 0, 11'b10100000010);
`else
      check_frame("post-reset(81)", 0, 11'b01100000010);
`endif
      check("post-reset ready after frame", bus.DataInReady, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
